light_fade_ctrl: RTL

Brightness sequencer for the stand light: takes debounced single-cycle button pulses (up/down/off), tracks a 5-step brightness level, and ramps the PWM duty smoothly toward that level's target instead of switching abruptly. It generates the LED PWM itself from a clock-enable prescaler on the system clock. An idle timer fades the light out automatically. It replaces the FSM/comparator/mux path between the button controllers and the LED pin.

---
 rtl/light_pkg.sv | 31 +++
 rtl/pwm_gen.sv | 47 ++++
 rtl/light_fade_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/light_pkg.sv
// Shared types and constants for the stand-light brightness sequencer.
// Holds the FSM state encoding and the level-to-duty lookup.
package light_pkg;

    typedef enum logic [1:0] {
        StOff  = 2'd0,
        StRamp = 2'd1,
        StHold = 2'd2
    } light_state_e;

    localparam int unsigned NUM_LEVELS = 5;
    localparam int unsigned LEVEL_W    = 3;
    localparam int unsigned DUTY_W     = 10;

    localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(NUM_LEVELS - 1);
    localparam logic [DUTY_W-1:0]  DUTY_MAX  = 10'd1023;

    function automatic logic [DUTY_W-1:0] level_duty(input logic [LEVEL_W-1:0] level);
        logic [DUTY_W-1:0] duty;
        duty = '0;
        case (level)
            3'd1:    duty = 10'd128;
            3'd2:    duty = 10'd384;
            3'd3:    duty = 10'd640;
            3'd4:    duty = DUTY_MAX;
            default: duty = '0;
        endcase
        return duty;
    endfunction

endpackage

// File: rtl/pwm_gen.sv
// LED PWM: a clock-enable prescaler steps a 0..1022 counter; output is
// registered (counter < duty), so duty 1023 is always on and duty 0 always off.
module pwm_gen
    import light_pkg::*;
#(
    parameter int unsigned PWM_DIV = 100
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [DUTY_W-1:0] i_duty,
    output logic              o_pwm
);

    localparam int unsigned DivW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [DivW-1:0]   DivLast = DivW'(PWM_DIV - 1);
    localparam logic [DUTY_W-1:0] CntLast = 10'd1022;

    logic [DivW-1:0]   div_q, div_d;
    logic [DUTY_W-1:0] cnt_q, cnt_d;
    logic              pwm_q, pwm_d;
    logic              pwm_en;

    always_comb begin
        pwm_en = (div_q == DivLast);
        div_d  = pwm_en ? '0 : div_q + 1'b1;
        cnt_d  = cnt_q;
        if (pwm_en) begin
            cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
        end
        pwm_d = (cnt_q < i_duty);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            div_q <= '0;
            cnt_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
            pwm_q <= pwm_d;
        end
    end

    assign o_pwm = pwm_q;

endmodule

// File: rtl/light_fade_ctrl.sv
// Brightness sequencer: button pulses pick a level, the duty ramps toward the
// level's target on ramp ticks, and an idle timer fades the light out from HOLD.
module light_fade_ctrl
    import light_pkg::*;
#(
    parameter int unsigned PWM_DIV  = 100,
    parameter int unsigned RAMP_DIV = 100_000,
    parameter int unsigned STEP     = 8,
    parameter int unsigned TIMEOUT  = 600_000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_btn_up,
    input  logic               i_btn_down,
    input  logic               i_btn_off,
    output logic               o_light_led,
    output logic [LEVEL_W-1:0] o_level,
    output logic [DUTY_W-1:0]  o_duty,
    output logic [1:0]         o_state
);

    localparam int unsigned RampW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int unsigned IdleW = $clog2(TIMEOUT + 1);
    localparam logic [RampW-1:0]  RampLast    = RampW'(RAMP_DIV - 1);
    localparam logic [IdleW-1:0]  IdleTimeout = IdleW'(TIMEOUT);
    localparam logic signed [10:0] StepS      = $signed(11'(STEP));

    light_state_e       state_q, state_d, state_btn;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [DUTY_W-1:0]  duty_q, duty_d;
    logic [RampW-1:0]   ramp_cnt_q, ramp_cnt_d;
    logic [IdleW-1:0]   idle_q, idle_d, idle_inc;

    logic               ramp_tick;
    logic               any_btn;
    logic [DUTY_W-1:0]  target;
    logic signed [10:0] diff;
    logic signed [10:0] stepped;
    logic [DUTY_W-1:0]  duty_next;

    always_comb begin
        ramp_tick  = (ramp_cnt_q == RampLast);
        ramp_cnt_d = ramp_tick ? '0 : ramp_cnt_q + 1'b1;
        any_btn    = i_btn_up | i_btn_down | i_btn_off;

        level_d = level_q;
        duty_d  = duty_q;
        idle_d  = idle_q;

        // Buttons resolve first so a coincident ramp tick steps toward the new target.
        if (i_btn_off) begin
            level_d = '0;
        end else if (i_btn_up) begin
            level_d = (level_q == LEVEL_MAX) ? level_q : level_q + 1'b1;
        end else if (i_btn_down) begin
            level_d = (level_q == '0) ? level_q : level_q - 1'b1;
        end

        state_btn = state_q;
        if (i_btn_off || (level_d != level_q)) begin
            state_btn = StRamp;
        end
        state_d = state_btn;

        target = level_duty(level_d);
        diff   = $signed({1'b0, target}) - $signed({1'b0, duty_q});
        if (diff > StepS) begin
            stepped = $signed({1'b0, duty_q}) + StepS;
        end else if (diff < -StepS) begin
            stepped = $signed({1'b0, duty_q}) - StepS;
        end else begin
            stepped = $signed({1'b0, target});
        end
        duty_next = stepped[10] ? '0 : stepped[9:0];

        idle_inc = idle_q + 1'b1;

        unique case (state_btn)
            StOff: begin
                duty_d = '0;
                idle_d = '0;
            end
            StRamp: begin
                idle_d = '0;
                if (ramp_tick) begin
                    duty_d = duty_next;
                    if (duty_next == target) begin
                        state_d = (level_d == '0) ? StOff : StHold;
                    end
                end
            end
            StHold: begin
                if (any_btn) begin
                    idle_d = '0;
                end else if (ramp_tick) begin
                    if (idle_inc == IdleTimeout) begin
                        idle_d  = '0;
                        level_d = '0;
                        state_d = StRamp;
                    end else begin
                        idle_d = idle_inc;
                    end
                end
            end
            default: begin
                state_d = StOff;
                level_d = '0;
                duty_d  = '0;
                idle_d  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= StOff;
            level_q    <= '0;
            duty_q     <= '0;
            ramp_cnt_q <= '0;
            idle_q     <= '0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            duty_q     <= duty_d;
            ramp_cnt_q <= ramp_cnt_d;
            idle_q     <= idle_d;
        end
    end

    pwm_gen #(
        .PWM_DIV (PWM_DIV)
    ) u_pwm_gen (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_duty  (duty_q),
        .o_pwm   (o_light_led)
    );

    assign o_level = level_q;
    assign o_duty  = duty_q;
    assign o_state = state_q;

endmodule
